la_acq_ctrl: RTL and testbench
==============================

Name: la_acq_ctrl

Overview:
- Acquisition sequencer for the PCI logic-analyzer capture RAM.
- Replaces the fixed "PCI_Targeted starts a 256-clock capture" with host-armed, mask/value-triggered capture and a programmable pre/post-trigger split.
- The circular buffer always holds exactly DEPTH valid samples around the trigger.
- Driven by a register interface decoded from PCI IO writes. Drives the write port of the 48-bit acquisition RAM.

Parameters:
ADDR_W, 8, capture RAM address width; DEPTH = 2^ADDR_W samples
POST_RST, 128, reset value of the post-trigger count register

Ports:
PCI_CLK  in  1  sole clock, rising edge
PCI_RSTn  in  1  asynchronous active-low reset
cfg_we  in  1  register write strobe, one cycle per write
cfg_addr  in  2  register select: 0 CTRL, 1 MASK, 2 VALUE, 3 POST
cfg_wdata  in  32  register write data
cfg_rdata  out  32  combinational readback of the register selected by cfg_addr
trig_data  in  32  trigger compare bus, aligned with the sample written this cycle
ext_trig  in  1  external trigger (e.g. PCI_Targeted), aligned with trig_data
wr_en  out  1  capture RAM write enable
wr_addr  out  ADDR_W  capture RAM write address
start_addr  out  ADDR_W  address of oldest sample, valid when done=1
done  out  1  capture complete, RAM readable

Behaviour:
- Reset: state=IDLE, wr_en=0, wr_addr=0, start_addr=0, done=0, MASK=0, VALUE=0, POST=POST_RST, ext_en=0, trig_addr=0, pre_cnt=0, post_cnt=0.
- Register writes:
  - CTRL bit0 ARM and bit1 ABORT are self-clearing pulses, never stored.
  - CTRL bit2 EXT_EN is stored.
  - POST uses bits [ADDR_W-1:0].
  - MASK and VALUE writes are accepted in any state.
  - POST writes are ignored in ARMED and TRIGGERED.
- Readback:
  - addr0: {trig_addr[ADDR_W-1:0] at [15:8], EXT_EN at [4], state[1:0] at [3:2], done at [0]}, rest 0.
  - addr1: MASK. addr2: VALUE. addr3: POST, zero-extended.
- Trigger: hit = ((trig_data & MASK) == (VALUE & MASK)) | (EXT_EN & ext_trig). MASK=0 with EXT_EN=0 means immediate trigger. hit is combinational and same-cycle.
- PRE = DEPTH-1-POST, computed mod DEPTH. PRE + 1 + POST = DEPTH.
- States: IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
  - IDLE: wr_en=0. ARM -> ARMED. Next cycle wr_addr=0, pre_cnt=0, done=0.
  - ARMED:
    - wr_en=1 every cycle; wr_addr increments and wraps DEPTH-1 -> 0.
    - pre_cnt saturates at PRE.
    - A hit is qualified only when pre_cnt==PRE; earlier hits are ignored.
    - On a qualified hit: trig_addr<=wr_addr (the trigger sample is written that cycle), post_cnt<=0, -> TRIGGERED. If POST==0, go directly to DONE instead.
  - TRIGGERED:
    - wr_en=1, wr_addr increments, post_cnt increments.
    - The cycle that writes the POST-th post-trigger sample (post_cnt==POST-1) is the last write.
    - Next state DONE; start_addr <= wr_addr+1 (mod DEPTH) = trig_addr-PRE.
  - DONE: wr_en=0, wr_addr held, done=1. ARM -> ARMED (restart). ABORT -> IDLE, done=0.
- ABORT in any state -> IDLE next cycle: wr_en=0, done=0, RAM contents untouched.
- ARM in ARMED or TRIGGERED restarts the capture: wr_addr=0, pre_cnt=0.
- ARM and ABORT in the same write: ABORT wins.
- Reset mid-capture: immediate return to reset values; no further writes.
- Total writes per completed capture: exactly DEPTH (PRE+1+POST), with no gaps and no duplicate addresses.

Test Plan:
- Reset, read addr3 -> 128. Read addr0 -> 0. wr_en=0 for 20 cycles.
- POST=128 (PRE=127), MASK=FFFFFFFF, VALUE=00000200, ARM. trig_data matches at sample 50 -> ignored. Match at sample 200 (wr_addr=200) -> trig_addr=200, 128 further writes, done=1, start_addr=73, total wr_en cycles=329.
- POST=0, MASK=0, EXT_EN=0, ARM -> triggers at pre_cnt=255 (wr_addr=255), DONE next cycle, start_addr=0, exactly 256 writes.
- POST=255, EXT_EN=1, MASK=FFFFFFFF, VALUE=DEADBEEF never matching. ext_trig on first armed cycle -> trig_addr=0, 255 post writes, start_addr=0.
- In TRIGGERED, write CTRL=3 (ARM|ABORT) -> IDLE next cycle, wr_en=0, done=0. Also verify a POST write during ARMED leaves POST unchanged.
- Deassert PCI_RSTn asynchronously mid-ARMED (between clock edges) -> wr_en, wr_addr, done go to 0 immediately. MASK=0, POST=128 after release.

Source files
------------

// File: rtl/la_acq_ctrl.sv
// Acquisition sequencer for the logic-analyzer capture RAM: host-armed, mask/value or
// external trigger, programmable pre/post-trigger split over a DEPTH-entry circular buffer.
module la_acq_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned POST_RST = 128
) (
  input  logic              PCI_CLK,
  input  logic              PCI_RSTn,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic [31:0]       trig_data,
  input  logic              ext_trig,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StTrig  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] AddrCtrl  = 2'd0;
  localparam logic [1:0] AddrMask  = 2'd1;
  localparam logic [1:0] AddrValue = 2'd2;
  localparam logic [1:0] AddrPost  = 2'd3;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrMax = '1;

  state_e              state_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   start_addr_q;
  logic                done_q;
  logic [31:0]         mask_q;
  logic [31:0]         value_q;
  logic [ADDR_W-1:0]   post_q;
  logic                ext_en_q;
  logic [ADDR_W-1:0]   trig_addr_q;
  logic [ADDR_W-1:0]   pre_cnt_q;
  logic [ADDR_W-1:0]   post_cnt_q;

  logic                ctrl_wr;
  logic                arm;
  logic                abort;
  logic [ADDR_W-1:0]   pre;
  logic                hit;
  logic                qual_hit;
  logic                post_last;
  logic [ADDR_W-1:0]   addr_inc;
  logic [7:0]          trig_field;

  always_comb begin
    ctrl_wr   = cfg_we && (cfg_addr == AddrCtrl);
    arm       = ctrl_wr && cfg_wdata[0];
    abort     = ctrl_wr && cfg_wdata[1];
    // DEPTH-1-POST taken modulo DEPTH; the buffer then holds PRE + 1 + POST = DEPTH samples.
    pre       = AddrMax - post_q;
    hit       = ((trig_data & mask_q) == (value_q & mask_q)) || (ext_en_q && ext_trig);
    qual_hit  = hit && (pre_cnt_q == pre);
    post_last = (post_cnt_q == (post_q - AddrOne));
    addr_inc  = wr_addr_q + AddrOne;
    trig_field = 8'(trig_addr_q);
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      AddrCtrl: begin
        cfg_rdata[15:8] = trig_field;
        cfg_rdata[4]    = ext_en_q;
        cfg_rdata[3:2]  = state_q;
        cfg_rdata[0]    = done_q;
      end
      AddrMask:  cfg_rdata = mask_q;
      AddrValue: cfg_rdata = value_q;
      AddrPost:  cfg_rdata = 32'(post_q);
      default:   cfg_rdata = '0;
    endcase
  end

  // Configuration registers; POST is frozen while a capture is in flight.
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      mask_q   <= '0;
      value_q  <= '0;
      post_q   <= ADDR_W'(POST_RST);
      ext_en_q <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        AddrCtrl:  ext_en_q <= cfg_wdata[2];
        AddrMask:  mask_q   <= cfg_wdata;
        AddrValue: value_q  <= cfg_wdata;
        AddrPost: begin
          if (state_q == StIdle || state_q == StDone) post_q <= cfg_wdata[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Capture sequencer with registered RAM write controls.
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state_q      <= StIdle;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      start_addr_q <= '0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (arm) begin
      state_q   <= StArmed;
      wr_en_q   <= 1'b1;
      wr_addr_q <= '0;
      pre_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: wr_en_q <= 1'b0;
        StArmed: begin
          if (pre_cnt_q != pre) pre_cnt_q <= pre_cnt_q + AddrOne;
          if (qual_hit) begin
            trig_addr_q <= wr_addr_q;
            post_cnt_q  <= '0;
            if (post_q == '0) begin
              // Trigger sample is the last one: buffer already full.
              state_q      <= StDone;
              wr_en_q      <= 1'b0;
              done_q       <= 1'b1;
              start_addr_q <= addr_inc;
            end else begin
              state_q   <= StTrig;
              wr_addr_q <= addr_inc;
            end
          end else begin
            wr_addr_q <= addr_inc;
          end
        end
        StTrig: begin
          if (post_last) begin
            state_q      <= StDone;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b1;
            start_addr_q <= addr_inc;
          end else begin
            wr_addr_q  <= addr_inc;
            post_cnt_q <= post_cnt_q + AddrOne;
          end
        end
        StDone: ;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign start_addr = start_addr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_la_acq_ctrl.sv
// Self-checking bench for la_acq_ctrl: directed captures plus randomized ones, each compared
// against a per-capture model that finds the trigger sample and expected write sequence.
module tb_la_acq_ctrl;

  localparam int Depth  = 256;
  localparam int NData  = 1024;
  localparam int CycMax = 1000;

  logic        PCI_CLK = 1'b0;
  logic        PCI_RSTn;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [31:0] trig_data;
  logic        ext_trig;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  start_addr;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [31:0] d_arr [NData];
  bit          e_arr [NData];

  la_acq_ctrl #(
    .ADDR_W   (8),
    .POST_RST (128)
  ) dut (
    .PCI_CLK    (PCI_CLK),
    .PCI_RSTn   (PCI_RSTn),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .trig_data  (trig_data),
    .ext_trig   (ext_trig),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .start_addr (start_addr),
    .done       (done)
  );

  always #5 PCI_CLK = ~PCI_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge PCI_CLK);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge PCI_CLK);
    cfg_we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge PCI_CLK);
    cfg_we = 1'b0; cfg_addr = a;
    #1 d = cfg_rdata;
  endtask

  // Per-armed-cycle trigger stimulus: random non-matching data except at planted indices.
  task automatic gen(input logic [31:0] mask, input logic [31:0] value, input int m0,
                     input int m1, input int x0);
    logic [31:0] r;
    for (int i = 0; i < NData; i++) begin
      r = $urandom;
      if (mask != 0 && ((r & mask) == (value & mask))) r = r ^ (mask & (~mask + 32'd1));
      if (i == m0 || i == m1) r = (value & mask) | ($urandom & ~mask);
      d_arr[i] = r;
      e_arr[i] = (i == x0);
    end
  endtask

  task automatic capture(input string tag, input int post, input logic [31:0] mask,
                         input logic [31:0] value, input bit ext_en, input int m0, input int m1,
                         input int x0, input int post_wr_at, input int abort_at);
    int pre, k, exp_n, errs, missing, lo;
    bit fin;
    bit seen [Depth];
    logic [31:0] rd, exp_ctl;
    int wq[$];
    pre = Depth - 1 - post;
    gen(mask, value, m0, m1, x0);
    // Trigger = first sample at or after PRE that hits.
    k = -1;
    for (int i = pre; i < NData; i++) begin
      if (((d_arr[i] & mask) == (value & mask)) || (ext_en && e_arr[i])) begin
        k = i;
        break;
      end
    end
    exp_n = (abort_at >= 0) ? abort_at + 1 : k + 1 + post;
    cfg_write(2'd3, 32'(post));
    cfg_write(2'd1, mask);
    cfg_write(2'd2, value);
    @(negedge PCI_CLK);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = {29'd0, ext_en, 2'b01};
    @(negedge PCI_CLK);
    fin = 1'b0;
    for (int i = 0; i < CycMax; i++) begin
      if (done === 1'b1) begin fin = 1'b1; break; end
      if (abort_at >= 0 && i > abort_at + 8) begin fin = 1'b1; break; end
      if (wr_en !== 1'b0) wq.push_back(int'(wr_addr));
      trig_data = d_arr[i];
      ext_trig  = e_arr[i];
      cfg_we    = 1'b0;
      if (i == post_wr_at) begin cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd7; end
      if (i == abort_at)   begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd3; end
      @(negedge PCI_CLK);
    end
    cfg_we = 1'b0; ext_trig = 1'b0;
    check($sformatf("%s.timeout", tag), 32'(fin), 32'd1);
    check($sformatf("%s.nwrites", tag), 32'(wq.size()), 32'(exp_n));
    errs = 0;
    foreach (wq[j]) if (wq[j] != j % Depth) errs++;
    check($sformatf("%s.addrseq", tag), 32'(errs), 32'd0);
    check($sformatf("%s.wr_en", tag), 32'(wr_en), 32'd0);
    if (abort_at < 0) begin
      foreach (seen[j]) seen[j] = 1'b0;
      lo = (wq.size() > Depth) ? wq.size() - Depth : 0;
      for (int j = lo; j < wq.size(); j++) seen[wq[j] % Depth] = 1'b1;
      missing = 0;
      foreach (seen[j]) if (!seen[j]) missing++;
      check($sformatf("%s.coverage", tag), 32'(missing), 32'd0);
      check($sformatf("%s.start", tag), 32'(start_addr), 32'((k + post + 1) % Depth));
      check($sformatf("%s.done", tag), 32'(done), 32'd1);
      exp_ctl = (32'(k % Depth) << 8) | (32'(ext_en) << 4) | 32'hd;
    end else begin
      check($sformatf("%s.done", tag), 32'(done), 32'd0);
      exp_ctl = 32'(k % Depth) << 8;
    end
    read_reg(2'd0, rd);
    check($sformatf("%s.ctrl", tag), rd, exp_ctl);
    read_reg(2'd3, rd);
    check($sformatf("%s.post", tag), rd, 32'(post));
  endtask

  initial begin
    logic [31:0] rd;
    int          hi_cnt;
    int          post, m1, x0;
    logic [31:0] mk;
    bit          ee;

    PCI_RSTn = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    trig_data = '0; ext_trig = 1'b0;
    repeat (3) @(negedge PCI_CLK);
    PCI_RSTn = 1'b1;

    read_reg(2'd3, rd);
    check("rst.post", rd, 32'd128);
    read_reg(2'd0, rd);
    check("rst.ctrl", rd, 32'd0);
    check("rst.wr_addr", 32'(wr_addr), 32'd0);
    check("rst.start", 32'(start_addr), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    hi_cnt = 0;
    repeat (20) begin
      @(negedge PCI_CLK);
      if (wr_en !== 1'b0) hi_cnt++;
    end
    check("rst.idle_writes", 32'(hi_cnt), 32'd0);

    // Early match at 50 ignored; qualified match at 200.
    capture("split128", 128, 32'hffff_ffff, 32'h0000_0200, 1'b0, 50, 200, -1, -1, -1);
    // MASK=0 with no external trigger fires as soon as qualified.
    capture("post0", 0, 32'h0, 32'h0, 1'b0, -1, -1, -1, -1, -1);
    capture("ext255", 255, 32'hffff_ffff, 32'hdead_beef, 1'b1, -1, -1, 0, -1, -1);

    for (int r = 0; r < 4; r++) begin
      post = int'($urandom_range(0, 255));
      if (r % 2 == 0) mk = $urandom;
      else mk = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31))
                | (32'd1 << $urandom_range(0, 31));
      ee = 1'($urandom_range(0, 1));
      x0 = int'($urandom_range(0, 400));
      m1 = (Depth - 1 - post) + int'($urandom_range(0, 200));
      capture($sformatf("rand%0d", r), post, mk, $urandom, ee, -1, m1, x0, -1, -1);
    end

    // POST write while armed is dropped; ARM|ABORT while triggered aborts.
    capture("abort", 100, 32'hffff_ffff, 32'h0000_0055, 1'b0, -1, 158, -1, 5, 200);

    cfg_write(2'd3, 32'd50);
    cfg_write(2'd1, 32'hffff_ffff);
    cfg_write(2'd2, 32'd1);
    trig_data = 32'd0;
    cfg_write(2'd0, 32'd1);
    repeat (30) @(negedge PCI_CLK);
    check("arst.armed", 32'(wr_en), 32'd1);
    #2 PCI_RSTn = 1'b0;
    #1;
    check("arst.wr_en", 32'(wr_en), 32'd0);
    check("arst.wr_addr", 32'(wr_addr), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    repeat (2) @(negedge PCI_CLK);
    PCI_RSTn = 1'b1;
    read_reg(2'd1, rd);
    check("arst.mask", rd, 32'd0);
    read_reg(2'd3, rd);
    check("arst.post", rd, 32'd128);
    read_reg(2'd0, rd);
    check("arst.ctrl", rd, 32'd0);
    hi_cnt = 0;
    repeat (10) begin
      @(negedge PCI_CLK);
      if (wr_en !== 1'b0) hi_cnt++;
    end
    check("arst.no_writes", 32'(hi_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
